// File: rtl/nios2_debug_slave_cmd_bridge_if.sv
// Command bridge bus bundle for the Nios II debug slave.
// Groups the virtual-JTAG side (update strobes, IR value, shift register),
// the consumer handshake (cmd_ready, decoded pulses, jdo/jir payload) and
// the status signals (pending, overflow, ovf_clr).
//   slave  : the bridge. JTAG/consumer inputs in, command/status out.
//   master : the environment that drives the strobes and consumes commands.
interface nios2_debug_slave_cmd_bridge_if #(
  parameter int DATA_W = 38,
  parameter int IR_W   = 2,
  parameter int DEPTH  = 4
);
  localparam int CH    = 2 ** IR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              vs_uir;
  logic              vs_udr;
  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic              cmd_ready;
  logic              ovf_clr;
  logic [DATA_W-1:0] jdo;
  logic [IR_W-1:0]   jir;
  logic [CH-1:0]     take_action;
  logic [CH-1:0]     take_no_action;
  logic [CNT_W-1:0]  pending;
  logic              overflow;

  modport slave (
    input  vs_uir, vs_udr, ir_in, sr, cmd_ready, ovf_clr,
    output jdo, jir, take_action, take_no_action, pending, overflow
  );

  modport master (
    output vs_uir, vs_udr, ir_in, sr, cmd_ready, ovf_clr,
    input  jdo, jir, take_action, take_no_action, pending, overflow
  );
endinterface

// File: rtl/nios2_debug_slave_cmd_bridge.sv
// System-clock-side command bridge for the Nios II debug slave.
// Synchronises the TCK-domain update-IR / update-DR levels, captures the
// IR and shift-register payload on each update-DR edge into a DEPTH-entry
// FIFO, and issues one decoded take_action / take_no_action pulse per
// command whenever the consumer asserts cmd_ready.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave modport (vs_uir, vs_udr, ir_in, sr, cmd_ready, ovf_clr
//              in; jdo, jir, take_action, take_no_action, pending,
//              overflow out)
module nios2_debug_slave_cmd_bridge #(
  parameter int DATA_W     = 38,
  parameter int IR_W       = 2,
  parameter int DEPTH      = 4,
  parameter int ACTION_BIT = 35
) (
  input  logic                          clk,
  input  logic                          reset_n,
  nios2_debug_slave_cmd_bridge_if.slave bus
);
  localparam int CH    = 2 ** IR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IR_W + DATA_W;

  // synchroniser stages and previous-value registers
  logic uir_s0_q, uir_s1_q, uir_prev_q;
  logic udr_s0_q, udr_s1_q, udr_prev_q;

  logic [IR_W-1:0]   ir_q, ir_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] jdo_q, jdo_d;
  logic [IR_W-1:0]   jir_q, jir_d;
  logic [CH-1:0]     act_q, act_d;
  logic [CH-1:0]     noact_q, noact_d;
  logic              ovf_q, ovf_d;

  logic              uir_edge, udr_edge;
  logic              full, push, drop, pop;
  logic [ENT_W-1:0]  head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_s0_q   <= 1'b0;
      uir_s1_q   <= 1'b0;
      uir_prev_q <= 1'b0;
      udr_s0_q   <= 1'b0;
      udr_s1_q   <= 1'b0;
      udr_prev_q <= 1'b0;
    end else begin
      uir_s0_q   <= bus.vs_uir;
      uir_s1_q   <= uir_s0_q;
      uir_prev_q <= uir_s1_q;
      udr_s0_q   <= bus.vs_udr;
      udr_s1_q   <= udr_s0_q;
      udr_prev_q <= udr_s1_q;
    end
  end

  always_comb begin
    uir_edge = uir_s1_q & ~uir_prev_q;
    udr_edge = udr_s1_q & ~udr_prev_q;
    // Fullness is judged on the registered count, so a pop in the same
    // cycle never makes room for a push that arrives at full.
    full     = (count_q == CNT_W'(DEPTH));
    push     = udr_edge & ~full;
    drop     = udr_edge & full;
    pop      = (count_q != '0) & bus.cmd_ready;
    head     = mem_q[rd_ptr_q];

    ir_d     = uir_edge ? bus.ir_in : ir_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    jdo_d   = jdo_q;
    jir_d   = jir_q;
    act_d   = '0;
    noact_d = '0;
    if (pop) begin
      jdo_d = head[DATA_W-1:0];
      jir_d = head[ENT_W-1:DATA_W];
      if (head[ACTION_BIT]) act_d   = CH'(1) << head[ENT_W-1:DATA_W];
      else                  noact_d = CH'(1) << head[ENT_W-1:DATA_W];
    end

    // a drop in the same cycle as a clear keeps the flag set
    if (drop)             ovf_d = 1'b1;
    else if (bus.ovf_clr) ovf_d = 1'b0;
    else                  ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      jdo_q    <= '0;
      jir_q    <= '0;
      act_q    <= '0;
      noact_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      jdo_q    <= jdo_d;
      jir_q    <= jir_d;
      act_q    <= act_d;
      noact_q  <= noact_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  // The push captures the IR held before any same-cycle update-IR edge.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ir_q, bus.sr};
  end

  assign bus.jdo            = jdo_q;
  assign bus.jir            = jir_q;
  assign bus.take_action    = act_q;
  assign bus.take_no_action = noact_q;
  assign bus.pending        = count_q;
  assign bus.overflow       = ovf_q;
endmodule
